// File: rtl/dispatcher_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dispatcher_pkg : shared tag types and controller state encoding          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package dispatcher_pkg;

  localparam int TAG_DEPTH = 64;
  localparam int TAG_W     = $clog2(TAG_DEPTH);

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    TAC_CLR  = 2'd0,
    TAC_INIT = 2'd1,
    TAC_RUN  = 2'd2
  } tac_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : one-hot round-robin grant starting at a rotating pointer    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [SUM_W-1:0] pos;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    pos   = '0;
    idx   = '0;
    // Scan from the pointer, wrapping once; first hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr_q} + SUM_W'(i);
      if (pos >= SUM_W'(NUM_REQ)) pos = pos - SUM_W'(NUM_REQ);
      idx = pos[PTR_W-1:0];
      if (en && (gnt == '0) && req[idx]) begin
        gnt[idx] = 1'b1;
        ptr_d    = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/tag_alloc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tag_alloc_ctrl : fills the free-tag FIFO, arbitrates allocation, recycles |
// | CDB tags and tracks free count / error flags.                  Rev 1.0   |
// +--------------------------------------------------------------------------+
module tag_alloc_ctrl
  import dispatcher_pkg::*;
#(
  parameter int DEPTH      = TAG_DEPTH,
  parameter int DATA_WIDTH = $clog2(DEPTH),
  parameter int NUM_REQ    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [DATA_WIDTH-1:0] tag_out,
  input  logic [DATA_WIDTH-1:0] cdb_tag,
  input  logic                  cdb_tag_valid,
  output logic [DATA_WIDTH-1:0] cdb_tag_tf,
  output logic                  cdb_tag_tf_valid,
  output logic                  ren_tf,
  input  logic [DATA_WIDTH-1:0] tagout_tf,
  input  logic                  ff_tf,
  input  logic                  ef_tf,
  output logic                  fifo_clr,
  output logic                  init_done,
  output logic [DATA_WIDTH:0]   free_count,
  output logic                  err_ovf,
  output logic                  err_init_cdb
);

  localparam int                    CNT_W    = DATA_WIDTH + 1;
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] LAST_TAG = DATA_WIDTH'(DEPTH - 1);

  tac_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]      free_q, free_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_init_cdb_q, err_init_cdb_d;
  logic                  grant_en;
  logic [NUM_REQ-1:0]    arb_gnt;

  // Outputs are forced quiet while rst is held, even though state sits in INIT.
  assign grant_en = (state_q == TAC_RUN) && !ef_tf && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (grant_en),
    .gnt (arb_gnt)
  );

  always_comb begin
    gnt              = arb_gnt;
    ren_tf           = |arb_gnt;
    tag_out          = (|arb_gnt) ? tagout_tf : '0;
    cdb_tag_tf       = '0;
    cdb_tag_tf_valid = 1'b0;
    fifo_clr         = 1'b0;
    init_done        = 1'b0;
    if (!rst) begin
      case (state_q)
        TAC_CLR:  fifo_clr = 1'b1;
        TAC_INIT: begin
          cdb_tag_tf       = fill_q;
          cdb_tag_tf_valid = 1'b1;
        end
        TAC_RUN:  begin
          init_done        = 1'b1;
          cdb_tag_tf       = cdb_tag;
          cdb_tag_tf_valid = cdb_tag_valid;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    free_d  = free_q;
    case (state_q)
      TAC_CLR: begin
        state_d = TAC_INIT;
        fill_d  = '0;
        free_d  = '0;
      end
      TAC_INIT: begin
        fill_d = (fill_q == LAST_TAG) ? '0 : fill_q + DATA_WIDTH'(1);
        if (fill_q == LAST_TAG) state_d = TAC_RUN;
        if (free_q != FULL_CNT) free_d = free_q + CNT_W'(1);
      end
      default: begin
        // A concurrent write and pop cancel out.
        if (cdb_tag_tf_valid && !ren_tf && (free_q != FULL_CNT))
          free_d = free_q + CNT_W'(1);
        else if (ren_tf && !cdb_tag_tf_valid && (free_q != '0))
          free_d = free_q - CNT_W'(1);
      end
    endcase
    if (flush) begin
      state_d = TAC_CLR;
      fill_d  = '0;
      free_d  = '0;
    end
    err_ovf_d      = err_ovf_q | ((state_q == TAC_RUN) && cdb_tag_valid && ff_tf);
    err_init_cdb_d = err_init_cdb_q | ((state_q != TAC_RUN) && cdb_tag_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= TAC_INIT;
      fill_q         <= '0;
      free_q         <= '0;
      err_ovf_q      <= 1'b0;
      err_init_cdb_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_q         <= fill_d;
      free_q         <= free_d;
      err_ovf_q      <= err_ovf_d;
      err_init_cdb_q <= err_init_cdb_d;
    end
  end

  assign free_count   = free_q;
  assign err_ovf      = err_ovf_q;
  assign err_init_cdb = err_init_cdb_q;

endmodule
`default_nettype wire

// File: tb/tb_tag_alloc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tag_alloc_ctrl : bench with FIFO model, tag-pool reference model and   |
// | randomized allocation/return traffic.                          Rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_tag_alloc_ctrl;

  localparam int DEPTH = 64;
  localparam int DW    = 6;
  localparam int NR    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [NR-1:0] req = '0;
  logic [DW-1:0] cdb_tag = '0;
  logic          cdb_tag_valid = 1'b0;
  logic [NR-1:0] gnt;
  logic [DW-1:0] tag_out, cdb_tag_tf;
  logic [DW-1:0] tagout_tf = '0;
  logic          cdb_tag_tf_valid, ren_tf, fifo_clr, init_done, err_ovf, err_init_cdb;
  logic          ff_tf = 1'b0;
  logic          ef_tf = 1'b1;
  logic [DW:0]   free_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tag_alloc_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req(req), .gnt(gnt), .tag_out(tag_out),
    .cdb_tag(cdb_tag), .cdb_tag_valid(cdb_tag_valid), .cdb_tag_tf(cdb_tag_tf),
    .cdb_tag_tf_valid(cdb_tag_tf_valid), .ren_tf(ren_tf), .tagout_tf(tagout_tf),
    .ff_tf(ff_tf), .ef_tf(ef_tf), .fifo_clr(fifo_clr), .init_done(init_done),
    .free_count(free_count), .err_ovf(err_ovf), .err_init_cdb(err_init_cdb)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // External FIFO model: first-word-fall-through, drops writes when full.
  logic [DW-1:0] fq[$];
  bit            outstanding[DEPTH];
  bit            op_pop, op_push, op_clr, was_full;
  logic [DW-1:0] op_wdata;

  always @(negedge clk) begin
    op_pop   = ren_tf;
    op_push  = cdb_tag_tf_valid;
    op_wdata = cdb_tag_tf;
    op_clr   = fifo_clr;
  end

  always @(posedge clk) begin
    #1;
    if (rst || op_clr) begin
      fq.delete();
      for (int i = 0; i < DEPTH; i++) outstanding[i] = 1'b0;
    end else begin
      was_full = (fq.size() == DEPTH);
      if (op_pop && fq.size() > 0) begin
        outstanding[fq[0]] = 1'b1;
        void'(fq.pop_front());
      end
      if (op_push && !was_full) fq.push_back(op_wdata);
    end
    ef_tf     = (fq.size() == 0);
    ff_tf     = (fq.size() == DEPTH);
    tagout_tf = (fq.size() > 0) ? fq[0] : '0;
  end

  // Reference model: phase as clear flag plus number of tags already filled.
  int            m_fill, m_free, m_ptr, gi;
  bit            m_clr, m_ovf, m_einit, run;
  logic [NR-1:0] e_gnt;
  logic          e_wv, e_clr, e_done;
  logic [DW-1:0] e_wt;

  always @(negedge clk) begin
    if (rst) begin
      m_fill = 0; m_free = 0; m_ptr = 0; m_clr = 0; m_ovf = 0; m_einit = 0;
    end
    run   = !m_clr && (m_fill >= DEPTH);
    e_gnt = '0; e_wv = 1'b0; e_wt = '0; e_clr = 1'b0; e_done = 1'b0; gi = -1;
    if (!rst) begin
      if (m_clr) e_clr = 1'b1;
      else if (!run) begin
        e_wv = 1'b1;
        e_wt = DW'(m_fill);
      end else begin
        e_done = 1'b1;
        e_wv   = cdb_tag_valid;
        e_wt   = cdb_tag;
        if (!ef_tf)
          for (int k = 0; k < NR; k++)
            if (gi < 0 && req[(m_ptr + k) % NR]) gi = (m_ptr + k) % NR;
        if (gi >= 0) e_gnt[gi] = 1'b1;
      end
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("ren_tf", 32'(ren_tf), 32'(gi >= 0));
    if (gi >= 0) chk("tag_out", 32'(tag_out), 32'(tagout_tf));
    chk("wr_valid", 32'(cdb_tag_tf_valid), 32'(e_wv));
    if (e_wv) chk("wr_tag", 32'(cdb_tag_tf), 32'(e_wt));
    chk("fifo_clr", 32'(fifo_clr), 32'(e_clr));
    chk("init_done", 32'(init_done), 32'(e_done));
    chk("free_count", 32'(free_count), 32'(m_free));
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
    chk("err_init_cdb", 32'(err_init_cdb), 32'(m_einit));
    if (!rst) begin
      if (cdb_tag_valid && !run) m_einit = 1'b1;
      if (cdb_tag_valid && run && ff_tf) m_ovf = 1'b1;
      if (gi >= 0) m_ptr = (gi + 1) % NR;
      if (flush) begin
        m_clr = 1'b1; m_fill = 0; m_free = 0;
      end else if (m_clr) begin
        m_clr = 1'b0; m_free = 0;
      end else if (!run) begin
        m_fill++;
        if (m_free < DEPTH) m_free++;
      end else begin
        m_free = m_free + int'(e_wv) - int'(gi >= 0);
        if (m_free > DEPTH) m_free = DEPTH;
        if (m_free < 0) m_free = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ret_tag(input int t);
    cdb_tag       = DW'(t);
    cdb_tag_valid = 1'b1;
    outstanding[t] = 1'b0;
    tick();
    cdb_tag_valid = 1'b0;
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
    chk(nm, 32'(init_done), 32'd1);
  endtask

  initial begin
    int n, s, t;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("t1_first_tag", 32'(cdb_tag_tf), 32'd0);
    chk("t1_first_valid", 32'(cdb_tag_tf_valid), 32'd1);
    chk("t1_not_done", 32'(init_done), 32'd0);
    repeat (63) tick();
    chk("t1_last_tag", 32'(cdb_tag_tf), 32'd63);
    tick();
    chk("t1_done", 32'(init_done), 32'd1);
    chk("t1_free64", 32'(free_count), 32'd64);

    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_gnt", 32'(gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("t2_tag", 32'(tag_out), 32'(i));
      tick();
    end
    req = 2'b00;
    #1;
    chk("t2_free60", 32'(free_count), 32'd60);

    req = 2'b11;
    n = 0;
    while (!ef_tf && n < 80) begin
      tick();
      n++;
    end
    chk("t3_drained", 32'(free_count), 32'd0);
    req = 2'b01;
    cdb_tag = 6'd5;
    cdb_tag_valid = 1'b1;
    #1;
    chk("t3_no_bypass", 32'(gnt), 32'd0);
    tick();
    cdb_tag_valid = 1'b0;
    #1;
    chk("t3_gnt_next", 32'(gnt), 32'd1);
    chk("t3_tag5", 32'(tag_out), 32'd5);
    tick();
    req = 2'b00;

    for (int i = 10; i < 20; i++) ret_tag(i);
    cdb_tag = 6'd9;
    cdb_tag_valid = 1'b1;
    outstanding[9] = 1'b0;
    req = 2'b01;
    #1;
    chk("t4_gnt", 32'(gnt), 32'd1);
    chk("t4_tag10", 32'(tag_out), 32'd10);
    tick();
    cdb_tag_valid = 1'b0;
    req = 2'b00;
    #1;
    chk("t4_free10", 32'(free_count), 32'd10);
    chk("t4_tail9", 32'(fq[$]), 32'd9);

    for (int i = 20; i < 30; i++) ret_tag(i);
    #1;
    chk("t5_free20", 32'(free_count), 32'd20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("t5_clr_pulse", 32'(fifo_clr), 32'd1);
    tick();
    chk("t5_clr_gone", 32'(fifo_clr), 32'd0);
    chk("t5_refill0", 32'(cdb_tag_tf), 32'd0);
    chk("t5_free0", 32'(free_count), 32'd0);
    repeat (4) tick();
    cdb_tag = 6'd33;
    cdb_tag_valid = 1'b1;
    tick();
    cdb_tag_valid = 1'b0;
    #1;
    chk("t5_err_init", 32'(err_init_cdb), 32'd1);
    wait_init("t5_init_timeout");
    chk("t5_free64", 32'(free_count), 32'd64);
    chk("t5_fifo64", 32'(fq.size()), 32'd64);

    cdb_tag = 6'd7;
    cdb_tag_valid = 1'b1;
    tick();
    cdb_tag_valid = 1'b0;
    #1;
    chk("t6_err_ovf", 32'(err_ovf), 32'd1);
    chk("t6_free_sat", 32'(free_count), 32'd64);
    repeat (5) tick();
    chk("t6_ovf_sticky", 32'(err_ovf), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_wv", 32'(cdb_tag_tf_valid), 32'd0);
    chk("t6_rst_free", 32'(free_count), 32'd0);
    chk("t6_rst_ovf", 32'(err_ovf), 32'd0);
    chk("t6_rst_einit", 32'(err_init_cdb), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("t6_restart_tag", 32'(cdb_tag_tf), 32'd0);
    chk("t6_restart_valid", 32'(cdb_tag_tf_valid), 32'd1);
    wait_init("t6_init_timeout");

    for (int cyc = 0; cyc < 600; cyc++) begin
      req = NR'($urandom_range(0, (1 << NR) - 1));
      flush = ($urandom_range(0, 99) == 0);
      cdb_tag_valid = 1'b0;
      if (init_done && !flush && $urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, DEPTH - 1);
        for (int j = 0; j < DEPTH; j++) begin
          t = (s + j) % DEPTH;
          if (!cdb_tag_valid && outstanding[t]) begin
            cdb_tag = DW'(t);
            cdb_tag_valid = 1'b1;
            outstanding[t] = 1'b0;
          end
        end
      end
      tick();
    end
    flush = 1'b0;
    cdb_tag_valid = 1'b0;
    req = '0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
